instruction_fetch: RTL

Fetch unit for the 8-bit processor. It sits between the program counter and `program_memory`, and drives the memory address. From the registered ROM byte stream it assembles complete 1- or 2-byte instructions (opcode plus optional operand). It hands each instruction to the decoder over a valid/ready handshake and accepts jump redirects from the execute stage.

---
 rtl/islemci_pkg.sv | 44 ++++
 rtl/opcode_length.sv | 16 +
 rtl/instruction_fetch.sv | 115 +++++++++++
 3 files changed

// File: rtl/islemci_pkg.sv
// Shared definitions for the 8-bit processor: opcode map, fetch FSM encoding
// and the top of the legal program address space.
package islemci_pkg;

    localparam logic [7:0] MEM_LIMIT = 8'h80;

    localparam logic [7:0] BOS           = 8'h00;

    localparam logic [7:0] ATLA          = 8'h20;
    localparam logic [7:0] ATLA_ESIT     = 8'h21;
    localparam logic [7:0] ATLA_FARKLI   = 8'h22;
    localparam logic [7:0] ATLA_BUYUK    = 8'h23;
    localparam logic [7:0] ATLA_KUCUK    = 8'h24;
    localparam logic [7:0] ATLA_ELDE     = 8'h25;
    localparam logic [7:0] ATLA_SIFIR    = 8'h26;
    localparam logic [7:0] ATLA_NEGATIF  = 8'h27;
    localparam logic [7:0] ATLA_TASMA    = 8'h28;

    localparam logic [7:0] TOPLA_AB      = 8'h42;
    localparam logic [7:0] CIKAR_AB      = 8'h43;
    localparam logic [7:0] VE_AB         = 8'h44;
    localparam logic [7:0] VEYA_AB       = 8'h45;
    localparam logic [7:0] OZEL_VEYA_AB  = 8'h46;
    localparam logic [7:0] DEGIL_A       = 8'h47;
    localparam logic [7:0] ARTIR_A       = 8'h48;
    localparam logic [7:0] DUSUR_B       = 8'h49;

    localparam logic [7:0] YUKLE_A_SABIT = 8'h86;
    localparam logic [7:0] YUKLE_B_SABIT = 8'h87;
    localparam logic [7:0] YUKLE_A_BELLEK = 8'h88;
    localparam logic [7:0] YUKLE_B_BELLEK = 8'h89;

    localparam logic [7:0] KAYDET_A      = 8'h96;
    localparam logic [7:0] KAYDET_B      = 8'h97;

    typedef enum logic [2:0] {
        ST_OP_REQ  = 3'd0,
        ST_OP_CAP  = 3'd1,
        ST_ARG_CAP = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_HALT    = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/opcode_length.sv
// Instruction length classifier: flags opcodes that carry one operand byte.
// Anything not listed is treated as a 1-byte instruction.
module opcode_length
    import islemci_pkg::*;
(
    input  logic [7:0] opcode,
    output logic       two_byte
);

    always_comb begin
        two_byte = ((opcode >= YUKLE_A_SABIT) && (opcode <= YUKLE_B_BELLEK)) ||
                   ((opcode >= KAYDET_A)      && (opcode <= KAYDET_B))       ||
                   ((opcode >= ATLA)          && (opcode <= ATLA_TASMA));
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: walks the registered ROM, assembles 1/2-byte instruction bundles
// for the decoder over valid/ready, and takes jump redirects from execute.
module instruction_fetch
    import islemci_pkg::*;
#(
    parameter logic [7:0] RESET_PC  = 8'h00,
    parameter logic [7:0] MEM_LIMIT = islemci_pkg::MEM_LIMIT
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] addr,
    input  logic [7:0] mem_data,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] instr_op,
    output logic [7:0] instr_arg,
    output logic       instr_two,
    output logic [7:0] instr_pc,
    input  logic       redirect,
    input  logic [7:0] redirect_pc,
    output logic       fault
);

    fetch_state_t state, state_nx;
    logic [7:0]   pc;
    logic [7:0]   pc_seq;
    logic [8:0]   arg_addr;
    logic         op_two;
    logic         take_redirect;

    opcode_length u_opcode_length (
        .opcode   (mem_data),
        .two_byte (op_two)
    );

    // Nine bits so that an operand address past 8'hFF still compares as illegal.
    assign arg_addr      = {1'b0, pc} + 9'd1;
    assign pc_seq        = pc + (instr_two ? 8'd2 : 8'd1);
    assign take_redirect = redirect && (state != ST_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_OP_REQ;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_OP_REQ:  state_nx = (pc >= MEM_LIMIT) ? ST_HALT : ST_OP_CAP;
            ST_OP_CAP: begin
                if (!op_two) begin
                    state_nx = ST_ISSUE;
                end else if (arg_addr >= {1'b0, MEM_LIMIT}) begin
                    state_nx = ST_HALT;
                end else begin
                    state_nx = ST_ARG_CAP;
                end
            end
            ST_ARG_CAP: state_nx = ST_ISSUE;
            ST_ISSUE:   state_nx = instr_ready ? ST_OP_REQ : ST_ISSUE;
            ST_HALT:    state_nx = ST_HALT;
            default:    state_nx = ST_OP_REQ;
        endcase
        if (take_redirect) begin
            state_nx = ST_OP_REQ;
        end
    end

    always_comb begin
        instr_valid = (state == ST_ISSUE);
        fault       = (state == ST_HALT);
    end

    // The operand address is presented during OP_CAP so its byte lands in ARG_CAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= RESET_PC;
            pc        <= RESET_PC;
            instr_op  <= 8'h00;
            instr_arg <= 8'h00;
            instr_two <= 1'b0;
            instr_pc  <= 8'h00;
        end else if (take_redirect) begin
            addr <= redirect_pc;
            pc   <= redirect_pc;
        end else begin
            case (state)
                ST_OP_REQ: begin
                    addr <= arg_addr[7:0];
                end
                ST_OP_CAP: begin
                    instr_op  <= mem_data;
                    instr_two <= op_two;
                    instr_pc  <= pc;
                    instr_arg <= 8'h00;
                end
                ST_ARG_CAP: begin
                    instr_arg <= mem_data;
                end
                ST_ISSUE: begin
                    if (instr_ready) begin
                        pc   <= pc_seq;
                        addr <= pc_seq;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
